nrzi_tx: RTL and testbench
==========================

# nrzi_tx

- Serial line transmitter: accepts bytes over a valid/ready handshake and emits them LSB-first on a single NRZI-encoded line (raw 0 = toggle, raw 1 = hold), with a sync preamble, bit stuffing and an end-of-frame idle.
- Transmit-side counterpart of the team's NRZI line receiver, which flags "no transition" as a 1.
- Sits between the byte-oriented framing logic and the output pin.
- All bit timing is paced by an external bit-rate strobe.

## Interface
Parameters:
- DATA_W, 8, byte width.
- STUFF_LEN, 6, run of consecutive raw 1s after which a raw 0 is inserted.
- SYNC_PAT, 8'h80, preamble sent LSB-first before each frame.
- EOP_BITS, 2, idle-level bit periods that close a frame.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- bit_en  in  1  bit-rate strobe; the line advances one bit period per clk edge with bit_en=1.
- tx_data  in  DATA_W  byte to send.
- tx_last  in  1  byte is the final one of its frame.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_ready  out  1  holding register empty; transfer on an edge with tx_valid & tx_ready.
- dout  out  1  NRZI line; idle level 1.
- busy  out  1  frame in progress (SYNC, DATA, STUFF or EOP).
- underrun  out  1  one-cycle pulse; a frame was closed because no byte was available.

## Operation
- Datapath: one-entry holding register {data, last} feeding a DATA_W shift register, plus a bit counter and ones counter (0..STUFF_LEN).
- States: IDLE, SYNC, DATA, STUFF, EOP.
- IDLE: dout=1, ones=0. When the holding register is full, go to SYNC and load SYNC_PAT into the shift register.
- SYNC/DATA: on each bit_en, shift out the LSB as the raw bit:
  - raw 0: dout toggles, ones resets to 0.
  - raw 1: dout holds, ones increments.
  - Stuffing and the ones count apply to sync bits too; the count carries across byte boundaries.
- STUFF: entered when ones reaches STUFF_LEN after a sent bit, including after the final data bit.
  - One bit period of raw 0: toggle, ones=0.
  - Then resume the pending bit, or go to EOP.
- Byte boundary, after the last bit of a byte and any pending stuff bit:
  - Current byte had last=1: go to EOP.
  - Else, holding register full: move it into the shift register with no gap bit, and clear the holding register.
  - Else: pulse underrun and go to EOP.
- EOP: dout is forced to 1 for EOP_BITS bit periods, then IDLE. A byte already held starts a new SYNC at the next bit_en.
- tx_ready is registered as ~hold_full; there is no combinational path from tx_valid. A byte may be accepted in any state.
- Reset (any state):
  - Next edge: state=IDLE, dout=1, tx_ready=1, busy=0, underrun=0, ones=0.
  - Holding and shift contents are discarded.

## Timing
- dout, busy and state change only on edges with bit_en=1. Exceptions: reset, and IDLE→SYNC, which occurs on the edge after the accept regardless of bit_en.
- First sync bit appears on dout at the first bit_en edge after entering SYNC.
- Frame length in bit periods = 8 + 8·N + stuffed bits + EOP_BITS.
- busy rises with entry to SYNC and falls on the edge that leaves EOP.
- underrun is high exactly one clk cycle.
- Holding-register refill: tx_ready rises the cycle after the shift-register load. At bit_en=1 every cycle, a producer has 7 cycles to present the next byte without underrun.

## Structure
- Package nrzi_pkg holds:
  - state enum (IDLE, SYNC, DATA, STUFF, EOP);
  - default SYNC_PAT, STUFF_LEN and EOP_BITS constants, shared with the receiver.
- Sub-module nrzi_line_enc contains the dout toggle/hold register and the ones/stuff counter. Its inputs are raw bit, bit strobe, force-idle and rst; its outputs are dout and stuff_req.

## Test plan
- bit_en=1 constantly; send 0xFF with last.
  - dout after accept: 0,1,0,1,0,1,0,0 (sync), 0,0,0,0,0, then 1 (stuff), then 1,1,1, then 1,1 (EOP).
  - 19 bit periods total; busy high for 19.
- Send 0x00 with last.
  - Data bits toggle every period: 1,0,1,0,1,0,1,0 after a sync ending at 0, then EOP 1,1.
  - No stuffing.
- Send 0xA5 then 0x3C (last) back-to-back, tx_valid held.
  - No gap between bytes, no stuffing, busy high for exactly 26 bit periods.
  - tx_ready low only while the holding register is full.
- bit_en every 4th cycle; send 0xFF with last.
  - Same dout sequence as the first scenario.
  - Changes only on strobe edges; busy high for 76 cycles.
- Send 0x55 without last and no follow-up byte.
  - underrun pulses one cycle after bit 16.
  - dout=1 for 2 periods, then IDLE.
- Assert rst during the 3rd data bit.
  - Next edge: dout=1, tx_ready=1, busy=0.
  - The next frame begins with a full sync and ones=0.

Source files
------------

// File: rtl/nrzi_pkg.sv
// Shared definitions for the NRZI line transmitter and its matching receiver:
// frame-sequencer states and the default line-protocol constants.
package nrzi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP
    } state_t;

    localparam logic [7:0] SYNC_PAT_DEF  = 8'h80;
    localparam int         STUFF_LEN_DEF = 6;
    localparam int         EOP_BITS_DEF  = 2;

endpackage

// File: rtl/nrzi_line_enc.sv
// NRZI line register (raw 0 toggles, raw 1 holds) with the consecutive-ones
// counter that requests a stuffed zero after STUFF_LEN ones.
module nrzi_line_enc
    import nrzi_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bit_en,
    input  logic i_raw_bit,
    input  logic i_force_idle,
    output logic o_dout,
    output logic o_stuff_req
);

    localparam int ONES_W = $clog2(STUFF_LEN + 1);

    logic [ONES_W-1:0] r_ones;
    logic              r_dout;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= 1'b1;
            r_ones <= '0;
        end else if (i_bit_en) begin
            if (i_force_idle) begin
                r_dout <= 1'b1;
                r_ones <= '0;
            end else if (i_raw_bit) begin
                r_ones <= r_ones + ONES_W'(1);
            end else begin
                r_dout <= ~r_dout;
                r_ones <= '0;
            end
        end
    end

    // Raised on the edge whose raw 1 completes the run, so the sequencer can
    // schedule the stuff bit for the very next period.
    assign o_stuff_req = i_bit_en & ~i_force_idle & i_raw_bit
                       & (r_ones == ONES_W'(STUFF_LEN - 1));
    assign o_dout      = r_dout;

endmodule

// File: rtl/nrzi_tx.sv
// Byte-to-line NRZI transmitter: one-entry holding register, shift register and
// frame sequencer (sync preamble, LSB-first data, bit stuffing, end-of-frame idle).
module nrzi_tx
    import nrzi_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                STUFF_LEN = STUFF_LEN_DEF,
    parameter logic [DATA_W-1:0] SYNC_PAT  = DATA_W'(SYNC_PAT_DEF),
    parameter int                EOP_BITS  = EOP_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic              underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int EOP_W = $clog2(EOP_BITS + 1);

    state_t             r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_shift, w_shift_nxt;
    logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic               r_cur_last, w_cur_last_nxt;
    logic               r_cur_sync, w_cur_sync_nxt;
    logic [EOP_W-1:0]   r_eop_cnt, w_eop_cnt_nxt;
    logic [DATA_W-1:0]  r_hold_data;
    logic               r_hold_last;
    logic               r_hold_full;
    logic               r_underrun, w_underrun_nxt;
    logic               w_accept, w_hold_take, w_boundary;
    logic               w_raw_bit, w_force_idle, w_stuff_req, w_dout;

    assign w_accept     = tx_valid & ~r_hold_full;
    assign w_raw_bit    = (r_state == ST_STUFF) ? 1'b0 : r_shift[0];
    assign w_force_idle = (r_state == ST_IDLE) || (r_state == ST_EOP);

    nrzi_line_enc #(
        .STUFF_LEN (STUFF_LEN)
    ) u_line_enc (
        .clk          (clk),
        .rst          (rst),
        .i_bit_en     (bit_en),
        .i_raw_bit    (w_raw_bit),
        .i_force_idle (w_force_idle),
        .o_dout       (w_dout),
        .o_stuff_req  (w_stuff_req)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_cur_last_nxt = r_cur_last;
        w_cur_sync_nxt = r_cur_sync;
        w_eop_cnt_nxt  = r_eop_cnt;
        w_hold_take    = 1'b0;
        w_underrun_nxt = 1'b0;
        w_boundary     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_state_nxt    = ST_SYNC;
                    w_shift_nxt    = SYNC_PAT;
                    w_bit_cnt_nxt  = '0;
                    w_cur_sync_nxt = 1'b1;
                    w_cur_last_nxt = 1'b0;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (bit_en) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (w_stuff_req)
                        w_state_nxt = ST_STUFF;
                    else if (r_bit_cnt == CNT_W'(DATA_W - 1))
                        w_boundary = 1'b1;
                end
            end
            ST_STUFF: begin
                // A full bit count means the stuff bit followed the byte's last bit.
                if (bit_en) begin
                    if (r_bit_cnt == CNT_W'(DATA_W))
                        w_boundary = 1'b1;
                    else
                        w_state_nxt = r_cur_sync ? ST_SYNC : ST_DATA;
                end
            end
            ST_EOP: begin
                if (bit_en) begin
                    w_eop_cnt_nxt = r_eop_cnt + EOP_W'(1);
                    if (r_eop_cnt == EOP_W'(EOP_BITS - 1)) begin
                        if (r_hold_full) begin
                            w_state_nxt    = ST_SYNC;
                            w_shift_nxt    = SYNC_PAT;
                            w_bit_cnt_nxt  = '0;
                            w_cur_sync_nxt = 1'b1;
                            w_cur_last_nxt = 1'b0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_boundary) begin
            if (r_cur_last) begin
                w_state_nxt   = ST_EOP;
                w_eop_cnt_nxt = '0;
            end else if (r_hold_full) begin
                w_state_nxt    = ST_DATA;
                w_shift_nxt    = r_hold_data;
                w_cur_last_nxt = r_hold_last;
                w_cur_sync_nxt = 1'b0;
                w_bit_cnt_nxt  = '0;
                w_hold_take    = 1'b1;
            end else begin
                w_state_nxt    = ST_EOP;
                w_eop_cnt_nxt  = '0;
                w_underrun_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold_full <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_underrun <= w_underrun_nxt;
            if (w_accept)
                r_hold_full <= 1'b1;
            else if (w_hold_take)
                r_hold_full <= 1'b0;
        end
    end

    // NOTE: datapath registers carry no reset; each is reloaded before it is
    // read, and the control flags above gate every use.
    always_ff @(posedge clk) begin
        r_shift    <= w_shift_nxt;
        r_bit_cnt  <= w_bit_cnt_nxt;
        r_cur_last <= w_cur_last_nxt;
        r_cur_sync <= w_cur_sync_nxt;
        r_eop_cnt  <= w_eop_cnt_nxt;
        if (w_accept) begin
            r_hold_data <= tx_data;
            r_hold_last <= tx_last;
        end
    end

    assign tx_ready = ~r_hold_full;
    assign dout     = w_dout;
    assign busy     = (r_state != ST_IDLE);
    assign underrun = r_underrun;

endmodule

// File: tb/tb_nrzi_tx.sv
// Self-checking bench for nrzi_tx: directed and randomized frames compared
// against a bit-list NRZI/stuffing reference model.
module tb_nrzi_tx;

    localparam int         EOP_N     = 2;
    localparam int         STUFF_N   = 6;
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    logic       clk = 1'b0;
    logic       rst, bit_en, tx_last, tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, dout, busy, underrun;

    always #5 clk = ~clk;

    nrzi_tx dut (
        .clk      (clk),
        .rst      (rst),
        .bit_en   (bit_en),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .dout     (dout),
        .busy     (busy),
        .underrun (underrun)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         edge_n = 0;
    int         stride = 1;
    logic [7:0] src_data[$];
    logic       src_last[$];
    logic [7:0] frame_bytes[$];
    logic       exp_q[$];
    logic       cap_q[$];
    int         busy_cyc, ur_cnt, ur_at, glitch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge: drive the producer and strobe, then record line activity.
    task automatic step();
        logic en_pre, busy_pre, acc, dout_pre, rst_pre;
        bit_en   = ((edge_n % stride) == 0);
        tx_valid = (src_data.size() != 0);
        tx_data  = tx_valid ? src_data[0] : 8'h00;
        tx_last  = tx_valid ? src_last[0] : 1'b0;
        en_pre   = bit_en;
        busy_pre = busy;
        acc      = tx_valid && tx_ready;
        dout_pre = dout;
        rst_pre  = rst;
        @(posedge clk);
        #1;
        edge_n++;
        if (acc) begin
            void'(src_data.pop_front());
            void'(src_last.pop_front());
            if (!rst_pre)
                check("ready_drop_after_accept", tx_ready, 1'b0);
        end
        if (!rst_pre) begin
            if (en_pre && busy_pre) cap_q.push_back(dout);
            if (busy) busy_cyc++;
            if (underrun) begin
                ur_cnt++;
                ur_at = cap_q.size();
            end
            if (!en_pre && dout !== dout_pre) glitch++;
        end
    endtask

    // Expected line levels per bit period: sync + data LSB-first, a zero after
    // every STUFF_N consecutive ones, NRZI from idle level 1, then EOP idle.
    task automatic build_expected();
        logic       raw[$];
        logic [7:0] sb;
        int         ones;
        logic       level;
        raw.delete();
        exp_q.delete();
        ones  = 0;
        level = 1'b1;
        sb    = SYNC_BYTE;
        for (int i = 0; i < 8; i++) raw.push_back(sb[i]);
        foreach (frame_bytes[k])
            for (int i = 0; i < 8; i++) raw.push_back(frame_bytes[k][i]);
        foreach (raw[j]) begin
            if (raw[j]) begin
                exp_q.push_back(level);
                ones++;
                if (ones == STUFF_N) begin
                    level = ~level;
                    exp_q.push_back(level);
                    ones = 0;
                end
            end else begin
                level = ~level;
                exp_q.push_back(level);
                ones = 0;
            end
        end
        for (int i = 0; i < EOP_N; i++) exp_q.push_back(1'b1);
    endtask

    task automatic run_frame(input string tag, input int s, input bit with_last);
        int budget;
        bit started;
        int n;
        stride = s;
        build_expected();
        // Align so SYNC is entered on a strobe edge: busy then spans P*stride cycles.
        while (((edge_n + 1) % stride) != 0) step();
        cap_q.delete();
        busy_cyc = 0;
        ur_cnt   = 0;
        ur_at    = -1;
        glitch   = 0;
        n = frame_bytes.size();
        for (int k = 0; k < n; k++) begin
            src_data.push_back(frame_bytes[k]);
            src_last.push_back(with_last && (k == n - 1));
        end
        started = 1'b0;
        budget  = 0;
        while (!(started && !busy) && budget < 2000) begin
            step();
            if (busy) started = 1'b1;
            budget++;
        end
        check($sformatf("%s.finished", tag), (budget < 2000), 1'b1);
        check($sformatf("%s.length", tag), cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < cap_q.size())
                check($sformatf("%s.bit%0d", tag, i), cap_q[i], exp_q[i]);
        check($sformatf("%s.busy_cycles", tag), busy_cyc, exp_q.size() * stride);
        check($sformatf("%s.underrun_pulses", tag), ur_cnt, with_last ? 0 : 1);
        if (!with_last)
            check($sformatf("%s.underrun_at", tag), ur_at, exp_q.size() - EOP_N);
        check($sformatf("%s.off_strobe_changes", tag), glitch, 0);
        check($sformatf("%s.ready_at_end", tag), tx_ready, 1'b1);
        check($sformatf("%s.dout_idle", tag), dout, 1'b1);
    endtask

    initial begin
        int budget;
        rst      = 1'b1;
        bit_en   = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        tx_valid = 1'b0;
        repeat (3) step();
        check("reset.dout", dout, 1'b1);
        check("reset.tx_ready", tx_ready, 1'b1);
        check("reset.busy", busy, 1'b0);
        check("reset.underrun", underrun, 1'b0);
        rst = 1'b0;
        repeat (2) step();

        frame_bytes = {8'hFF};
        run_frame("ff", 1, 1'b1);
        frame_bytes = {8'h00};
        run_frame("zero", 1, 1'b1);
        frame_bytes = {8'hA5, 8'h3C};
        run_frame("b2b", 1, 1'b1);
        frame_bytes = {8'hFF};
        run_frame("ff_div4", 4, 1'b1);
        frame_bytes = {8'h55};
        run_frame("underrun", 1, 1'b0);
        frame_bytes = {8'hFC};
        run_frame("stuff_tail", 1, 1'b1);

        // Abort a frame on its third data bit, then confirm a clean restart.
        stride = 1;
        cap_q.delete();
        src_data.push_back(8'hFF);
        src_last.push_back(1'b1);
        budget = 0;
        while (cap_q.size() < 10 && budget < 200) begin
            step();
            budget++;
        end
        check("abort.reached_bit", cap_q.size(), 10);
        rst = 1'b1;
        step();
        check("abort.dout", dout, 1'b1);
        check("abort.tx_ready", tx_ready, 1'b1);
        check("abort.busy", busy, 1'b0);
        check("abort.underrun", underrun, 1'b0);
        rst = 1'b0;
        frame_bytes = {8'hFF};
        run_frame("after_rst", 1, 1'b1);

        for (int f = 0; f < 6; f++) begin
            int nb;
            nb = $urandom_range(1, 4);
            frame_bytes.delete();
            for (int k = 0; k < nb; k++) begin
                case ($urandom_range(0, 3))
                    0:       frame_bytes.push_back(8'($urandom));
                    1:       frame_bytes.push_back(8'hFF);
                    2:       frame_bytes.push_back(8'h7F);
                    default: frame_bytes.push_back(8'hFE);
                endcase
            end
            run_frame($sformatf("rnd%0d", f), $urandom_range(1, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
